// File: rtl/memory_game_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : memory_game_if
// Brief    : Board-side signal bundle of the memory-tester game: buttons,
//            switches, status LEDs and 7-segment outputs.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface memory_game_if;
  logic       auth_button;
  logic       log_out;
  logic       rng_button;
  logic [3:0] toggle_user;
  logic [3:0] toggle_pass;
  logic [3:0] toggle_answer;
  logic       red_led_user;
  logic       green_led_user;
  logic       red_led_rom;
  logic       green_led_rom;
  logic       red_led_ram;
  logic       green_led_ram;
  logic       loose;
  logic [6:0] flash_seg;
  logic [6:0] level_seg;
  logic [6:0] seg_answer;

  // Board / stimulus side
  modport master (
    output auth_button, log_out, rng_button, toggle_user, toggle_pass, toggle_answer,
    input  red_led_user, green_led_user, red_led_rom, green_led_rom,
           red_led_ram, green_led_ram, loose, flash_seg, level_seg, seg_answer
  );

  // Game logic side
  modport slave (
    input  auth_button, log_out, rng_button, toggle_user, toggle_pass, toggle_answer,
    output red_led_user, green_led_user, red_led_rom, green_led_rom,
           red_led_ram, green_led_ram, loose, flash_seg, level_seg, seg_answer
  );
endinterface
`default_nettype wire

// File: rtl/memory_game_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : memory_game_top
// Brief    : Memory-tester game. Login (user ID, ROM password, RAM password),
//            then five levels of flashing an LFSR digit sequence that the
//            player must re-enter.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module memory_game_top #(
  parameter int          FLASH_CYCLES = 8,
  parameter logic [3:0]  USER_ID      = 4'h8,
  parameter logic [15:0] ROM_PW       = 16'h256F,
  parameter logic [15:0] RAM_PW_INIT  = 16'h1234,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  wire logic    clock,
  input  wire logic    rst,
  memory_game_if.slave game
);

  localparam int c_FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [c_FLASH_W-1:0] c_FLASH_MAX = c_FLASH_W'(FLASH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_USER    = 3'd0,
    S_ROM     = 3'd1,
    S_RAM     = 3'd2,
    S_IDLE    = 3'd3,
    S_CAPTURE = 3'd4,
    S_FLASH   = 3'd5,
    S_ANSWER  = 3'd6
  } state_t;

  // Hex digit to {g,f,e,d,c,b,a}, active-high
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Index of the last sequence digit: lengths 3,4,6,6,7 for levels 1..5
  function automatic logic [2:0] last_idx(input logic [2:0] lvl);
    case (lvl)
      3'd1:       return 3'd2;
      3'd2:       return 3'd3;
      3'd3, 3'd4: return 3'd5;
      default:    return 3'd6;
    endcase
  endfunction

  state_t                 r_state, w_state_next;
  logic [2:0]             r_auth_sync, r_rng_sync;
  logic [7:0]             r_lfsr;
  logic [1:0]             r_digit_cnt;
  logic [11:0]            r_entry;
  logic [15:0]            r_ram_pw;
  logic [3:0]             r_buf [8];
  logic [2:0]             r_idx, r_flash_idx, r_level;
  logic [c_FLASH_W-1:0]   r_flash_cnt;
  logic                   r_red_user, r_green_user, r_red_rom, r_green_rom;
  logic                   r_red_ram, r_green_ram, r_loose, r_show_level;
  logic                   w_auth_raw, w_rng_raw, w_auth_press, w_rng_press;
  logic [15:0]            w_pw_full;
  logic [2:0]             w_last_idx;
  logic                   w_answer_bad;

  // Anything but a solid 0 counts as released, so an undriven button never presses
  assign w_auth_raw   = (game.auth_button !== 1'b0);
  assign w_rng_raw    = (game.rng_button !== 1'b0);
  assign w_auth_press = r_auth_sync[2] & ~r_auth_sync[1];
  assign w_rng_press  = r_rng_sync[2] & ~r_rng_sync[1];
  assign w_pw_full    = {r_entry, game.toggle_pass};
  assign w_last_idx   = last_idx(r_level);
  assign w_answer_bad = (game.toggle_answer != r_buf[r_idx]);

  // Two synchroniser flops plus one history flop for falling-edge detection
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_auth_sync <= 3'b111;
      r_rng_sync  <= 3'b111;
    end else begin
      r_auth_sync <= {r_auth_sync[1:0], w_auth_raw};
      r_rng_sync  <= {r_rng_sync[1:0], w_rng_raw};
    end
  end

  // Free-running Fibonacci LFSR, taps 8,6,5,4 (maximal length, never zero)
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) r_lfsr <= LFSR_SEED;
    else      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  // State register
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) r_state <= S_USER;
    else      r_state <= w_state_next;
  end

  // Next-state decode; log_out overrides every state
  always_comb begin
    w_state_next = r_state;
    if (game.log_out) begin
      w_state_next = S_USER;
    end else begin
      case (r_state)
        S_USER:    if (w_auth_press && game.toggle_user == USER_ID) w_state_next = S_ROM;
        S_ROM:     if (w_auth_press && r_digit_cnt == 2'd3 && w_pw_full == ROM_PW)
                     w_state_next = S_RAM;
        S_RAM:     if (w_auth_press && r_digit_cnt == 2'd3 && w_pw_full == r_ram_pw)
                     w_state_next = S_IDLE;
        S_IDLE:    if (w_rng_press) w_state_next = S_CAPTURE;
        S_CAPTURE: if (r_idx == w_last_idx) w_state_next = S_FLASH;
        S_FLASH:   if (r_flash_cnt == c_FLASH_MAX && r_flash_idx == w_last_idx)
                     w_state_next = S_ANSWER;
        S_ANSWER:  if (w_auth_press && (w_answer_bad || r_idx == w_last_idx))
                     w_state_next = S_IDLE;
        default:   w_state_next = S_USER;
      endcase
    end
  end

  // Login evaluation, sequence capture/flash counters, answer checking and level
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_red_user   <= 1'b0; r_green_user <= 1'b0;
      r_red_rom    <= 1'b0; r_green_rom  <= 1'b0;
      r_red_ram    <= 1'b0; r_green_ram  <= 1'b0;
      r_loose      <= 1'b0; r_show_level <= 1'b0;
      r_level      <= 3'd1; r_idx        <= 3'd0;
      r_flash_idx  <= 3'd0; r_flash_cnt  <= '0;
      r_digit_cnt  <= 2'd0; r_entry      <= 12'h000;
      r_ram_pw     <= RAM_PW_INIT;
      for (int i = 0; i < 8; i++) r_buf[i] <= 4'h0;
    end else if (game.log_out) begin
      // RAM password survives a log-out; only a reset reloads it
      r_red_user   <= 1'b0; r_green_user <= 1'b0;
      r_red_rom    <= 1'b0; r_green_rom  <= 1'b0;
      r_red_ram    <= 1'b0; r_green_ram  <= 1'b0;
      r_loose      <= 1'b0; r_show_level <= 1'b0;
      r_level      <= 3'd1; r_idx        <= 3'd0;
      r_flash_idx  <= 3'd0; r_flash_cnt  <= '0;
      r_digit_cnt  <= 2'd0; r_entry      <= 12'h000;
      for (int i = 0; i < 8; i++) r_buf[i] <= 4'h0;
    end else begin
      case (r_state)
        S_USER: if (w_auth_press) begin
          if (game.toggle_user == USER_ID) begin
            r_green_user <= 1'b1;
            r_red_user   <= 1'b0;
          end else begin
            r_red_user   <= 1'b1;
          end
        end
        S_ROM: if (w_auth_press) begin
          if (r_digit_cnt == 2'd3) begin
            r_digit_cnt <= 2'd0;
            r_red_rom   <= (w_pw_full != ROM_PW);
            if (w_pw_full == ROM_PW) r_green_rom <= 1'b1;
          end else begin
            r_digit_cnt <= r_digit_cnt + 2'd1;
            r_entry     <= w_pw_full[11:0];
          end
        end
        S_RAM: if (w_auth_press) begin
          if (r_digit_cnt == 2'd3) begin
            r_digit_cnt <= 2'd0;
            r_red_ram   <= (w_pw_full != r_ram_pw);
            if (w_pw_full == r_ram_pw) begin
              r_green_ram  <= 1'b1;
              r_show_level <= 1'b1;
            end
          end else begin
            r_digit_cnt <= r_digit_cnt + 2'd1;
            r_entry     <= w_pw_full[11:0];
          end
        end
        S_IDLE: if (w_rng_press) begin
          r_loose <= 1'b0;
          r_idx   <= 3'd0;
        end
        S_CAPTURE: begin
          r_buf[r_idx] <= r_lfsr[3:0];
          if (r_idx == w_last_idx) begin
            r_idx       <= 3'd0;
            r_flash_idx <= 3'd0;
            r_flash_cnt <= '0;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        S_FLASH: begin
          if (r_flash_cnt == c_FLASH_MAX) begin
            r_flash_cnt <= '0;
            r_flash_idx <= r_flash_idx + 3'd1;
          end else begin
            r_flash_cnt <= r_flash_cnt + c_FLASH_W'(1);
          end
        end
        S_ANSWER: if (w_auth_press) begin
          if (w_answer_bad) begin
            r_loose <= 1'b1;
            r_level <= 3'd1;
          end else if (r_idx == w_last_idx) begin
            r_level <= (r_level == 3'd5) ? 3'd1 : r_level + 3'd1;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign game.red_led_user   = r_red_user;
  assign game.green_led_user = r_green_user;
  assign game.red_led_rom    = r_red_rom;
  assign game.green_led_rom  = r_green_rom;
  assign game.red_led_ram    = r_red_ram;
  assign game.green_led_ram  = r_green_ram;
  assign game.loose          = r_loose;
  assign game.flash_seg      = (r_state == S_FLASH) ? seg7(r_buf[r_flash_idx]) : 7'h00;
  assign game.level_seg      = r_show_level ? seg7({1'b0, r_level}) : 7'h00;
  assign game.seg_answer     = seg7(game.toggle_answer);

endmodule
`default_nettype wire

// File: tb/tb_memory_game_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_memory_game_top
// Brief    : Self-checking bench for memory_game_top: login paths, random
//            play of the levels against a reference model, log-out and
//            asynchronous reset.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_memory_game_top;

  localparam logic [7:0] SEED = 8'hA5;

  logic clock = 1'b0;
  logic rst   = 1'b0;

  memory_game_if bus ();

  memory_game_top dut (
    .clock (clock),
    .rst   (rst),
    .game  (bus)
  );

  always #5 clock = ~clock;

  // Count of clock edges seen since reset released (= number of LFSR steps)
  int cyc;
  always @(posedge clock or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;
  int exp_level;
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int n_tab [6] = '{0, 3, 4, 6, 6, 7};
  logic [3:0] cur_d [8];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // LFSR state after n steps from the seed
  function automatic logic [7:0] lfsr_nth(input int n);
    logic [7:0] s;
    s = SEED;
    for (int k = 0; k < n; k++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return s;
  endfunction

  task automatic press_auth();
    bus.auth_button = 1'b0;
    repeat (3) tick();
    bus.auth_button = 1'b1;
    repeat (3) tick();
  endtask

  task automatic enter_code(input logic [15:0] code, input bit is_rom);
    for (int k = 3; k >= 0; k--) begin
      bus.toggle_pass = code[k*4 +: 4];
      press_auth();
    end
  endtask

  // Press rng after a random pause; the press registers three edges later and
  // the sequence is the low nibble of the next N LFSR states.
  task automatic start_level(output int n);
    logic [7:0] s;
    int c0;
    n = n_tab[exp_level];
    repeat ($urandom_range(0, 12)) tick();
    bus.rng_button = 1'b0;
    c0 = cyc;
    for (int i = 0; i < n; i++) begin
      s = lfsr_nth(c0 + 3 + i);
      cur_d[i] = s[3:0];
    end
    repeat (3) tick();
    bus.rng_button = 1'b1;
    chk("loose_cleared_on_start", bus.loose, 1'b0);
    repeat (n) tick();
  endtask

  task automatic play_level(input int wrong_at);
    int n;
    logic exp_loose;
    start_level(n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) begin
        chk("flash_digit", bus.flash_seg, seg_tab[cur_d[i]]);
        tick();
      end
    chk("flash_blank_after", bus.flash_seg, 7'h00);
    for (int i = 0; i < n; i++) begin
      bus.toggle_answer = (i == wrong_at) ? cur_d[i] + 4'h1 : cur_d[i];
      press_auth();
      if (i == wrong_at) break;
    end
    if (wrong_at >= 0 && wrong_at < n) begin
      exp_level = 1;
      exp_loose = 1'b1;
    end else begin
      exp_level = (exp_level == 5) ? 1 : exp_level + 1;
      exp_loose = 1'b0;
    end
    chk("loose_after_level", bus.loose, exp_loose);
    chk("level_seg_after_level", bus.level_seg, seg_tab[exp_level]);
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_leds"}, {bus.red_led_user, bus.green_led_user, bus.red_led_rom,
                         bus.green_led_rom, bus.red_led_ram, bus.green_led_ram}, 6'b0);
    chk({tag, "_loose"}, bus.loose, 1'b0);
    chk({tag, "_flash_seg"}, bus.flash_seg, 7'h00);
    chk({tag, "_level_seg"}, bus.level_seg, 7'h00);
  endtask

  task automatic login();
    bus.toggle_user = 4'h8;
    press_auth();
    chk("login_green_user", bus.green_led_user, 1'b1);
    enter_code(16'h256F, 1'b1);
    chk("login_green_rom", bus.green_led_rom, 1'b1);
    enter_code(16'h1234, 1'b0);
    chk("login_green_ram", bus.green_led_ram, 1'b1);
    chk("login_level_seg", bus.level_seg, seg_tab[1]);
  endtask

  initial begin
    int n;
    logic [3:0] v;
    bus.auth_button   = 1'b1;
    bus.rng_button    = 1'b1;
    bus.log_out       = 1'b0;
    bus.toggle_user   = 4'h0;
    bus.toggle_pass   = 4'h0;
    bus.toggle_answer = 4'h0;
    repeat (2) tick();
    chk_all_reset("reset");
    rst = 1'b1;
    tick();

    // Answer echo is combinational
    for (int i = 0; i < 6; i++) begin
      v = 4'($urandom_range(0, 15));
      bus.toggle_answer = v;
      #1;
      chk("seg_answer", bus.seg_answer, seg_tab[v]);
    end

    // rng press before login is ignored
    bus.rng_button = 1'b0;
    repeat (3) tick();
    bus.rng_button = 1'b1;
    repeat (12) tick();
    chk("rng_ignored_flash", bus.flash_seg, 7'h00);
    chk("rng_ignored_level", bus.level_seg, 7'h00);

    // User ID
    bus.toggle_user = 4'hC;
    press_auth();
    chk("user_bad_red", bus.red_led_user, 1'b1);
    chk("user_bad_green", bus.green_led_user, 1'b0);
    bus.toggle_user = 4'h8;
    press_auth();
    chk("user_ok_green", bus.green_led_user, 1'b1);
    chk("user_ok_red", bus.red_led_user, 1'b0);

    // ROM password: wrong, then correct re-entry
    enter_code(16'h2560, 1'b1);
    chk("rom_bad_red", bus.red_led_rom, 1'b1);
    chk("rom_bad_green", bus.green_led_rom, 1'b0);
    enter_code(16'h256F, 1'b1);
    chk("rom_ok_green", bus.green_led_rom, 1'b1);
    chk("rom_ok_red", bus.red_led_rom, 1'b0);

    // RAM password
    chk("ram_before_level_seg", bus.level_seg, 7'h00);
    enter_code(16'h1234, 1'b0);
    chk("ram_ok_green", bus.green_led_ram, 1'b1);
    chk("ram_ok_red", bus.red_led_ram, 1'b0);
    chk("ram_level_seg", bus.level_seg, seg_tab[1]);
    exp_level = 1;

    // Level 1 won, level 2 lost on the 2nd digit, then five wins wrap to 1
    play_level(-1);
    play_level(1);
    for (int k = 0; k < 5; k++) play_level(-1);
    chk("wrap_level_seg", bus.level_seg, seg_tab[1]);
    chk("wrap_loose", bus.loose, 1'b0);

    // log_out during FLASH
    start_level(n);
    repeat (5) tick();
    chk("pre_logout_flash", bus.flash_seg, seg_tab[cur_d[0]]);
    bus.log_out = 1'b1;
    tick();
    bus.log_out = 1'b0;
    chk_all_reset("logout");
    exp_level = 1;
    login();

    // Asynchronous reset mid-ANSWER
    start_level(n);
    repeat (8 * n) tick();
    bus.toggle_answer = cur_d[0];
    press_auth();
    rst = 1'b0;
    #1;
    chk_all_reset("async_reset");
    tick();
    rst = 1'b1;
    tick();
    bus.toggle_user = 4'h8;
    press_auth();
    chk("after_reset_user_green", bus.green_led_user, 1'b1);
    chk("after_reset_level_seg", bus.level_seg, 7'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
